// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with in-order memory requests,
// redirect flush with stale-response dropping, and a small instruction buffer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int          CW  = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, rsp_pc, target;
    logic [CW-1:0] outstanding, drop, count;
    logic [CW-1:0] outstanding_nxt, drop_nxt, count_nxt, wr_idx;
    logic [31:0]   buf_data [DEPTH];
    logic [31:0]   buf_pc   [DEPTH];
    logic          req_fire, out_fire, rsp_keep;

    assign target         = redirect_pc & 32'hFFFF_FFFC;
    assign imem_req_valid = state == RUN && !redirect_valid && int'(outstanding) + int'(count) < DEPTH;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign out_fire       = instr_valid && instr_ready;
    assign rsp_keep       = imem_rsp_valid && drop == '0 && !redirect_valid;
    assign instr_valid    = count != '0;
    assign instr          = instr_valid ? buf_data[0] : NOP;
    assign instr_pc       = instr_valid ? buf_pc[0] : rsp_pc;
    assign wr_idx         = count - CW'(out_fire);

    // A redirect turns every outstanding request into a stale response to drop.
    always_comb begin
        outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_nxt        = redirect_valid ? outstanding_nxt : drop - CW'(imem_rsp_valid && drop != '0);
        count_nxt       = redirect_valid ? '0 : count + CW'(rsp_keep) - CW'(out_fire);
        state_nxt       = redirect_valid ? (outstanding_nxt != '0 ? DRAIN : RUN) :
                          state == BOOT ? RUN :
                          state == DRAIN && drop_nxt == '0 ? RUN : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding_nxt;
            drop        <= drop_nxt;
            count       <= count_nxt;
            fetch_pc    <= redirect_valid ? target : req_fire ? fetch_pc + 32'd4 : fetch_pc;
            rsp_pc      <= redirect_valid ? target : rsp_keep ? rsp_pc + 32'd4 : rsp_pc;
        end
    end

    // Shift buffer: entry 0 is always the head, so instr is a plain register mux.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (out_fire && i < DEPTH - 1) begin
                buf_data[i] <= buf_data[i < DEPTH - 1 ? i + 1 : i];
                buf_pc[i]   <= buf_pc[i < DEPTH - 1 ? i + 1 : i];
            end
            if (rsp_keep && CW'(i) == wr_idx) begin
                buf_data[i] <= imem_rsp_data;
                buf_pc[i]   <= rsp_pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized memory/decoder/redirect stimulus with a scoreboard
// holding the expected instruction stream.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr, instr_pc;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;

    exp_t        sb[$];
    mem_t        mem_q[$];
    int          total = 0, bad = 0, cyc = 0;
    int          p_ready = 100, p_iready = 100, p_redir = 0, max_lat = 1;
    logic [31:0] exp_fetch = RESET_PC, exp_next = RESET_PC;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Memory and decoder model: drives inputs for the coming rising edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
            redirect_valid = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b0;
        end else begin
            imem_req_ready = $urandom_range(99) < p_ready;
            instr_ready    = $urandom_range(99) < p_iready;
            redirect_valid = $urandom_range(99) < p_redir;
            redirect_pc    = $urandom_range(3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_q[0].addr);
                mem_q.delete(0);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
        end
    end

    // Monitor: checks current outputs, then applies the handshakes of the coming edge.
    initial forever begin
        exp_t e;
        mem_t m;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_req_addr", imem_req_addr, RESET_PC);
            check("rst_instr_valid", 32'(instr_valid), 32'd0);
            check("rst_instr", instr, NOP);
            check("rst_instr_pc", instr_pc, RESET_PC);
        end else begin
            check("occupancy", 32'(int'(dut.count) > DEPTH || int'(dut.outstanding) + int'(dut.count) > DEPTH), 32'd0);
            if (!instr_valid) begin
                check("idle_instr", instr, NOP);
                check("idle_pc", instr_pc, exp_next);
            end
            if (instr_valid && instr_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_instr: got pc %h, none expected", instr_pc);
                end else begin
                    check("instr_pc", instr_pc, sb[0].pc);
                    check("instr", instr, sb[0].data);
                    exp_next = sb[0].pc + 32'd4;
                    sb.delete(0);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_fetch);
                e.pc = exp_fetch; e.data = mem_word(exp_fetch);
                sb.push_back(e);
                m.addr = imem_req_addr; m.due = cyc + 1 + int'($urandom_range(max_lat, 1));
                mem_q.push_back(m);
                exp_fetch += 32'd4;
            end
            if (redirect_valid) begin
                check("req_during_redirect", 32'(imem_req_valid), 32'd0);
                sb.delete();
                exp_fetch = redirect_pc & 32'hFFFF_FFFC;
                exp_next  = exp_fetch;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #3;
    endtask

    initial begin
        int waited;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("boot_instr_valid", 32'(instr_valid), 32'd0);
        check("run_req_valid", 32'(imem_req_valid), 32'd1);
        tick(1);
        check("fill_instr_valid", 32'(instr_valid), 32'd0);
        tick(1);
        check("first_instr_valid", 32'(instr_valid), 32'd1);
        check("first_instr_pc", instr_pc, RESET_PC);
        tick(20);
        p_iready = 0;
        tick(10);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_instr_valid", 32'(instr_valid), 32'd1);
        p_iready = 100;
        tick(10);
        p_ready = 70; p_iready = 70; p_redir = 8; max_lat = 3;
        tick(3000);
        p_ready = 100; p_iready = 100; p_redir = 0; max_lat = 1;
        tick(10);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_req_valid", 32'(imem_req_valid), 32'd0);
        check("async_req_addr", imem_req_addr, RESET_PC);
        check("async_instr_valid", 32'(instr_valid), 32'd0);
        check("async_instr", instr, NOP);
        check("async_instr_pc", instr_pc, RESET_PC);
        sb.delete(); mem_q.delete();
        exp_fetch = RESET_PC; exp_next = RESET_PC;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("restart_instr_pc", instr_pc, RESET_PC);
        p_ready = 70; p_iready = 70; p_redir = 8; max_lat = 3;
        tick(300);
        p_ready = 0; p_iready = 100; p_redir = 0;
        waited = 0;
        while ((sb.size() != 0 || mem_q.size() != 0) && waited < 100) begin
            tick(1);
            waited++;
        end
        if (waited >= 100) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d expected words left, want 0", sb.size());
        end
        tick(2);
        check("final_instr_valid", 32'(instr_valid), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
